// File: rtl/fs_pkg.sv
// Shared types and helpers for the digit-serial Ferrari-Stefanelli multiplier.
package fs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fs_state_e;

    localparam int unsigned FsWidthDefault = 8;

    // Number of 2-bit digits in an operand of the given width.
    function automatic int unsigned digit_count(input int unsigned width);
        return width / 2;
    endfunction

    // Two-input NAND, the primitive the 2x2 cell is built from.
    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

endpackage

// File: rtl/fs_mul2x2.sv
// Combinational 2-bit x 2-bit Ferrari-Stefanelli multiplier cell, NAND-only.
module fs_mul2x2
    import fs_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] z
);

    logic n00, n10, n01, n11;
    logic p00, p11;
    logic x_t, x_l, x_r;
    logic z2_n, z3_n;

    always_comb begin
        n00 = nand2(a[0], b[0]);
        n10 = nand2(a[1], b[0]);
        n01 = nand2(a[0], b[1]);
        n11 = nand2(a[1], b[1]);
        p00 = nand2(n00, n00);
        p11 = nand2(n11, n11);

        // a1b0 ^ a0b1 equals the XOR of the complemented partial products.
        x_t = nand2(n10, n01);
        x_l = nand2(n10, x_t);
        x_r = nand2(n01, x_t);

        // z2 = a1b1 & ~(a0b0); z3 = a1b1 & a0b0.
        z2_n = nand2(p11, n00);
        z3_n = nand2(p11, p00);

        z[0] = p00;
        z[1] = nand2(x_l, x_r);
        z[2] = nand2(z2_n, z2_n);
        z[3] = nand2(z3_n, z3_n);
    end

endmodule

// File: rtl/fs_serial_mult.sv
// Digit-serial unsigned multiplier: one 2x2 digit product per cycle into a 2*WIDTH accumulator.
// Optional FS_ZERO_SKIP_EN: a zero operand finishes in one cycle without entering RUN.
module fs_serial_mult
    import fs_pkg::*;
#(
    parameter int unsigned WIDTH = FsWidthDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned N    = digit_count(WIDTH);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    fs_state_e          state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
    logic [IdxW-1:0]    i_q, i_d, j_q, j_d;

    logic [1:0]         a_dig, b_dig;
    logic [3:0]         pp;
    logic [2*WIDTH-1:0] pp_ext, pp_shifted;
    logic [IdxW:0]      digit_pos;

    assign a_dig = a_q[{i_q, 1'b0} +: 2];
    assign b_dig = b_q[{j_q, 1'b0} +: 2];

    fs_mul2x2 u_cell (
        .a (a_dig),
        .b (b_dig),
        .z (pp)
    );

    always_comb begin
        pp_ext      = '0;
        pp_ext[3:0] = pp;
        digit_pos   = {1'b0, i_q} + {1'b0, j_q};
        pp_shifted  = pp_ext << {digit_pos, 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StRun;
`ifdef FS_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        product_d = '0;
                        state_d   = StDone;
                    end
`endif
                end
            end
            StRun: begin
                acc_d = acc_q + pp_shifted;
                if (j_q == LastIdx) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                    if (i_q == LastIdx) begin
                        i_d       = '0;
                        product_d = acc_d;
                        state_d   = StDone;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_fs_serial_mult.sv
// Self-checking bench for fs_serial_mult (WIDTH=8 and WIDTH=2) and the fs_mul2x2 cell.
module tb_fs_serial_mult;

    localparam int unsigned W  = 8;
    localparam int unsigned ND = W / 2;

`ifdef FS_ZERO_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           busy, done;
    logic [2*W-1:0] product;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2;
    logic [3:0] product2;

    logic [1:0] m_a = '0, m_b = '0;
    logic [3:0] m_z;

    int checks = 0;
    int errors = 0;
    longint unsigned model_prod = 0;

    always #5 clk = ~clk;

    fs_serial_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    fs_serial_mult #(.WIDTH(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .a       (a2),
        .b       (b2),
        .busy    (busy2),
        .done    (done2),
        .product (product2)
    );

    fs_mul2x2 u_cell (
        .a (m_a),
        .b (m_b),
        .z (m_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction; expectations come from plain arithmetic and the timing rules.
    task automatic run_op(input int unsigned av, input int unsigned bv, input string tag);
        longint unsigned exp_p;
        int unsigned exp_lat;
        int n;
        bit busy_ok, hold_ok;
        exp_p   = longint'(av) * longint'(bv);
        exp_lat = (Skip && (av == 0 || bv == 0)) ? 1 : ND * ND + 1;
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (product !== model_prod[2*W-1:0]) hold_ok = 1'b0;
            tick();
            n++;
        end
        check($sformatf("%s latency", tag), longint'(n + 1), longint'(exp_lat));
        check($sformatf("%s product", tag), product, exp_p);
        check($sformatf("%s busy_at_done", tag), busy, 1);
        check($sformatf("%s busy_run", tag), busy_ok, 1);
        check($sformatf("%s product_hold", tag), hold_ok, 1);
        model_prod = exp_p;
        tick();
        check($sformatf("%s done_pulse", tag), done, 0);
        check($sformatf("%s idle_busy", tag), busy, 0);
    endtask

    initial begin
        int pulses;
        int n;
        longint unsigned got;
        int unsigned ra, rb;

        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        rst = 1'b0;
        tick();

        run_op(13, 11, "13x11");
        run_op(255, 255, "255x255");
        run_op(3, 3, "3x3_b2b");

        // Start pulsed mid-RUN must be ignored.
        a = 8'd200;
        b = 8'd150;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        got = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                a = 8'd1;
                b = 8'd1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                pulses++;
                got = product;
            end
        end
        check("ignore_start pulses", pulses, 1);
        check("ignore_start product", got, 30000);
        model_prod = 30000;

        // Reset in RUN cycle 8 discards the partial result and clears product.
        a = 8'd99;
        b = 8'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst busy", busy, 0);
        check("midrun_rst done", done, 0);
        check("midrun_rst product", product, 0);
        model_prod = 0;
        run_op(2, 7, "2x7_after_rst");

        run_op(0, 200, "0x200");
        run_op(200, 0, "200x0");

        for (int k = 0; k < 20; k++) begin
            ra = $urandom_range(255, 0);
            rb = $urandom_range(255, 0);
            if (k == 7) ra = 0;
            run_op(ra, rb, $sformatf("rand%0d", k));
        end

        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                m_a = 2'(x);
                m_b = 2'(y);
                #1;
                check($sformatf("cell %0dx%0d", x, y), m_z, longint'(x * y));
            end
        end

        a2 = 2'd3;
        b2 = 2'd2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
            tick();
            n++;
        end
        check("w2 latency", longint'(n + 1), 2);
        check("w2 product", product2, 6);
        check("w2 busy", busy2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fs_serial_mult.md
# fs_serial_mult

Digit-serial unsigned multiplier built around the 2x2 Ferrari-Stefanelli cell. The block latches two WIDTH-bit operands and splits each into 2-bit digits. It feeds one digit pair per cycle to the 2x2 cell and accumulates the shifted 4-bit partial products into a 2*WIDTH-bit product. It is both the upstream operand feeder and the downstream consumer of the 2x2 array, and it is the next step from the single-cell datapath toward byte-wide multiplication.

## Interface
- WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 digits per operand
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, sampled with start
- b  in  WIDTH  multiplier, sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  result; held until next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge:
  - latch a and b into a_q and b_q
  - acc <= 0, digit indices i <= 0, j <= 0
  - go to RUN
- RUN, each edge:
  - pp = cell(a_q[2i+1:2i], b_q[2j+1:2j]), a 4-bit value
  - acc <= acc + (pp << 2*(i+j))
  - j increments; when j = N-1, j wraps to 0 and i increments
  - at the edge that processes i = j = N-1: product <= final acc, go to DONE
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Arithmetic is unsigned. The acc width is 2*WIDTH. The maximum sum is (2^WIDTH - 1)^2, so acc never overflows and no carry out exists.
- start is ignored while busy=1, including during the DONE cycle. Operand changes while busy have no effect.
- rst=1 at any edge, including mid-RUN:
  - state <= IDLE
  - busy=0, done=0, product=0, acc=0, indices=0
  - a partial result is discarded and never appears on product

## Timing
- Reset values: busy=0, done=0, product=0.
- Let E0 be the edge that samples start.
  - RUN covers edges E1..E(N*N).
  - product updates at E(N*N).
  - done is high in the cycle after E(N*N).
  - busy rises after E0 and falls after E(N*N+1).
- Latency from the start edge to done high is N*N+1 cycles; WIDTH=8 gives 16 RUN cycles and 17 cycles total.
- Minimum start-to-start spacing is N*N+2 cycles. A start asserted in the first IDLE cycle after DONE is accepted.
- The 2x2 cell is combinational, with one pass per cycle. The cell output is registered only through acc.

## Configuration
- FS_ZERO_SKIP_EN
  - Defined: in IDLE, if start=1 and (a==0 or b==0), E0 sets product <= 0 and goes directly to DONE. done is high in the cycle after E0, for a latency of 1 cycle, and busy is high for that single DONE cycle. RUN is never entered for such operands.
  - Undefined: zero operands take the full N*N-cycle path and yield product=0.

## Structure
- Shared package fs_pkg holds:
  - state encoding typedef (IDLE, RUN, DONE)
  - localparam for the default WIDTH
  - a function computing the digit count N
- One sub-module: fs_mul2x2, the combinational 2-bit x 2-bit Ferrari-Stefanelli cell.
  - Ports: a[1:0], b[1:0], z[3:0].
  - Built from the team's two-input NAND primitive.
  - Instantiated once.
- The top level holds the FSM, the operand registers, the index counters, the shifter and the accumulator.

## Test plan
- WIDTH=8, a=13, b=11, start one cycle -> done high exactly 17 cycles after the start edge, product=143, busy high throughout RUN/DONE.
- a=255, b=255 -> product=65025; then a=3, b=3 back-to-back with start in the first IDLE cycle -> product=9, the previous product holding until that done.
- Start pulsed again at cycle 5 of RUN with a=1, b=1 -> ignored; the original result appears, and only one done pulse occurs.
- rst asserted at RUN cycle 8 -> next cycle busy=0, done=0, product=0; a new start with 2x7 -> product=14 after 17 cycles.
- a=0, b=200: with FS_ZERO_SKIP_EN defined -> done one cycle after the start edge, product=0. Without it -> done after 17 cycles, product=0.
- Exhaustive fs_mul2x2 sweep of all 16 digit pairs -> z=a*b; and WIDTH=2 top level, a=3, b=2 -> done after 2 cycles, product=6.
